// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared widths and enumerations for the mem_master bus
// initiator and its PC sub-module.
//   ADDR_W / DATA_W : memory address and data widths
//   state_e         : access FSM states (IDLE, ACCESS, RESP)
//   kind_e          : kind of the access in flight (FETCH, DATA)
package mem_master_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } kind_e;

endpackage

// File: rtl/mem_master_pc_reg.sv
// pc_reg: program counter for mem_master.
//   clk, rst_n    : clock, synchronous active-low reset (PC -> RESET_PC)
//   load/load_val : jump request; has priority over the fetch increment
//   fetch_access  : a fetch is in its ACCESS cycle
//   fetch_resp    : a fetch is in its RESP cycle (increment point)
//   pc            : current program counter
//   squash        : a jump is killing the fetch in flight this cycle
module pc_reg
  import mem_master_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              fetch_access,
  input  logic              fetch_resp,
  output logic [ADDR_W-1:0] pc,
  output logic              squash
);

  logic [ADDR_W-1:0] pc_r;
  // Remembers a jump taken during ACCESS so the following RESP does not
  // increment the freshly loaded target.
  logic              squashed_r;

  assign pc     = pc_r;
  assign squash = load & (fetch_access | fetch_resp);

  // PC update: load wins over increment; increment wraps modulo 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      squashed_r <= 1'b0;
    end else begin
      squashed_r <= load & fetch_access;
      if (load) begin
        pc_r <= load_val;
      end else if (fetch_resp && !squashed_r) begin
        pc_r <= pc_r + 8'd1;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

endmodule

// File: rtl/mem_master.sv
// mem_master: bus initiator for the unified instruction/data memory.
// Serialises instruction fetches and data loads/stores onto one memory port
// with a three-state FSM (IDLE -> ACCESS -> RESP); data beats fetch in IDLE.
//   clk, rst_n                     : clock, synchronous active-low reset
//   fetch_req / instr_valid, instr : fetch request and response
//   pc, pc_load, pc_load_val       : program counter and jump
//   d_valid, d_we, d_addr, d_wdata : data request, accepted on d_ready
//   d_rsp_valid, d_rdata           : data response
//   wr_fault                       : protected store was dropped
//   mem_addr, mem_wdata, mem_rw    : registered memory port
//   mem_rdata                      : combinational memory read data
// Optional feature macro: MEM_MASTER_WPROT_EN -- when defined, stores below
// PROT_TOP are acknowledged but never written and flagged on wr_fault.
module mem_master
  import mem_master_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] PROT_TOP = 8'h10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              wr_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_r;
  kind_e             kind_r;
  logic              we_r;
  logic              fault_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_rw_r;
  logic [DATA_W-1:0] instr_r;
  logic              instr_valid_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              d_rsp_valid_r;
  logic              wr_fault_r;

  logic              prot_hit_s;
  logic              fetch_access_s;
  logic              fetch_resp_s;
  logic              squash_s;
  logic [ADDR_W-1:0] pc_s;

`ifdef MEM_MASTER_WPROT_EN
  assign prot_hit_s = d_we & (d_addr < PROT_TOP);
`else
  // Protection compiled out: no store is ever blocked, so wr_fault stays 0.
  logic unused_prot_top_s;
  assign unused_prot_top_s = ^PROT_TOP;
  assign prot_hit_s        = 1'b0;
`endif

  assign fetch_access_s = (state_r == ACCESS) && (kind_r == FETCH);
  assign fetch_resp_s   = (state_r == RESP) && (kind_r == FETCH);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (pc_load),
    .load_val     (pc_load_val),
    .fetch_access (fetch_access_s),
    .fetch_resp   (fetch_resp_s),
    .pc           (pc_s),
    .squash       (squash_s)
  );

  assign pc          = pc_s;
  assign d_ready     = (state_r == IDLE);
  assign instr       = instr_r;
  // A jump arriving during RESP still kills the pending instr_valid pulse.
  assign instr_valid = instr_valid_r & ~squash_s;
  assign d_rdata     = d_rdata_r;
  assign d_rsp_valid = d_rsp_valid_r;
  assign wr_fault    = wr_fault_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  // Gating with rst_n keeps a store cut by reset from writing on that edge.
  assign mem_rw      = mem_rw_r & rst_n;

  // Access FSM with the memory-port and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      kind_r        <= FETCH;
      we_r          <= 1'b0;
      fault_r       <= 1'b0;
      mem_addr_r    <= 8'h00;
      mem_wdata_r   <= 8'h00;
      mem_rw_r      <= 1'b0;
      instr_r       <= 8'h00;
      instr_valid_r <= 1'b0;
      d_rdata_r     <= 8'h00;
      d_rsp_valid_r <= 1'b0;
      wr_fault_r    <= 1'b0;
    end else begin
      instr_valid_r <= 1'b0;
      d_rsp_valid_r <= 1'b0;
      wr_fault_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (d_valid) begin
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
            mem_rw_r    <= d_we & ~prot_hit_s;
            we_r        <= d_we;
            fault_r     <= prot_hit_s;
            kind_r      <= DATA;
            state_r     <= ACCESS;
          end else if (fetch_req) begin
            mem_addr_r  <= pc_s;
            mem_rw_r    <= 1'b0;
            we_r        <= 1'b0;
            fault_r     <= 1'b0;
            kind_r      <= FETCH;
            state_r     <= ACCESS;
          end else begin
            state_r     <= IDLE;
          end
        end
        ACCESS: begin
          mem_rw_r <= 1'b0;
          state_r  <= RESP;
          if (kind_r == DATA) begin
            if (!we_r) begin
              d_rdata_r <= mem_rdata;
            end
            d_rsp_valid_r <= 1'b1;
            wr_fault_r    <= fault_r;
          end else if (!squash_s) begin
            instr_r       <= mem_rdata;
            instr_valid_r <= 1'b1;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          mem_rw_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

`ifdef MEM_MASTER_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_req;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] pc;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       d_valid;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_ready;
  logic       d_rsp_valid;
  logic [7:0] d_rdata;
  logic       wr_fault;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_rw;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_master #(
    .RESET_PC (8'h00),
    .PROT_TOP (8'h10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .d_valid     (d_valid),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ready     (d_ready),
    .d_rsp_valid (d_rsp_valid),
    .d_rdata     (d_rdata),
    .wr_fault    (wr_fault),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rw      (mem_rw),
    .mem_rdata   (mem_rdata)
  );

  // Memory model: write on the edge while mem_rw is high; bench preload port.
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] <= mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    tick();
    pre_we = 1'b0;
  endtask

  // Store (we=1) or load (we=0) through a full IDLE->ACCESS->RESP->IDLE pass.
  task automatic data_op(input logic we, input logic [7:0] a, input logic [7:0] v,
                         input logic exp_rw, input logic exp_fault);
    d_valid = 1'b1; d_we = we; d_addr = a; d_wdata = v;
    check("d_ready_idle", d_ready, 1'b1);
    tick();
    d_valid = 1'b0;
    check("acc_mem_addr", mem_addr, a);
    check("acc_mem_rw", mem_rw, exp_rw);
    check("acc_d_ready", d_ready, 1'b0);
    if (we) check("acc_mem_wdata", mem_wdata, v);
    tick();
    check("resp_d_rsp_valid", d_rsp_valid, 1'b1);
    check("resp_mem_rw", mem_rw, 1'b0);
    check("resp_wr_fault", wr_fault, exp_fault);
    tick();
    check("idle_d_rsp_valid", d_rsp_valid, 1'b0);
    check("idle_wr_fault", wr_fault, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;
    d_valid = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;

    preload(8'h00, 8'h21); preload(8'h01, 8'h1B); preload(8'h02, 8'h30);
    preload(8'h03, 8'h77); preload(8'hFF, 8'hE7); preload(8'h40, 8'hC4);
    preload(8'h05, 8'h55); preload(8'h10, 8'h66); preload(8'h20, 8'h11);

    // Reset state
    check("rst_pc", pc, 8'h00);
    check("rst_mem_rw", mem_rw, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_d_ready", d_ready, 1'b1);

    // Back-to-back fetches: pulses at cycles 2, 5, 8
    rst_n = 1'b1;
    fetch_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("f_instr_valid", instr_valid, (k % 3 == 2) ? 1'b1 : 1'b0);
      if (k == 2) check("f_instr0", instr, 8'h21);
      if (k == 5) check("f_instr1", instr, 8'h1B);
      if (k == 8) check("f_instr2", instr, 8'h30);
      if (k == 4) check("f_mem_addr1", mem_addr, 8'h01);
    end
    fetch_req = 1'b0;
    tick();
    check("f_pc_end", pc, 8'h03);
    check("f_idle_valid", instr_valid, 1'b0);

    // Store FB<-AA then load it back
    data_op(1'b1, 8'hFB, 8'hAA, 1'b1, 1'b0);
    check("st_mem_FB", mem[8'hFB], 8'hAA);
    check("st_rw_idle", mem_rw, 1'b0);
    d_valid = 1'b1; d_we = 1'b0; d_addr = 8'hFB;
    tick();
    d_valid = 1'b0;
    check("ld_rw", mem_rw, 1'b0);
    tick();
    check("ld_rsp", d_rsp_valid, 1'b1);
    check("ld_rdata", d_rdata, 8'hAA);
    tick();
    check("ld_rsp_off", d_rsp_valid, 1'b0);
    check("ld_rdata_held", d_rdata, 8'hAA);

    // Data and fetch together: data first, PC untouched by it
    d_valid = 1'b1; d_we = 1'b0; d_addr = 8'hFB; fetch_req = 1'b1;
    check("pri_d_ready", d_ready, 1'b1);
    tick();
    d_valid = 1'b0;
    check("pri_addr_data", mem_addr, 8'hFB);
    tick();
    check("pri_d_rsp", d_rsp_valid, 1'b1);
    check("pri_no_instr", instr_valid, 1'b0);
    check("pri_pc", pc, 8'h03);
    tick();
    tick();
    check("pri_addr_fetch", mem_addr, 8'h03);
    tick();
    check("pri_instr_valid", instr_valid, 1'b1);
    check("pri_instr", instr, 8'h77);
    fetch_req = 1'b0;
    tick();
    check("pri_pc_after", pc, 8'h04);

    // PC wrap at FF
    pc_load = 1'b1; pc_load_val = 8'hFF;
    tick();
    pc_load = 1'b0;
    check("wrap_pc_loaded", pc, 8'hFF);
    fetch_req = 1'b1;
    tick();
    tick();
    check("wrap_instr_valid", instr_valid, 1'b1);
    check("wrap_instr", instr, 8'hE7);
    fetch_req = 1'b0;
    tick();
    check("wrap_pc", pc, 8'h00);

    // Jump during ACCESS squashes the fetch
    fetch_req = 1'b1;
    tick();
    check("sq_acc_addr", mem_addr, 8'h00);
    pc_load = 1'b1; pc_load_val = 8'h40;
    tick();
    pc_load = 1'b0;
    check("sq_no_valid", instr_valid, 1'b0);
    check("sq_instr_held", instr, 8'hE7);
    check("sq_pc", pc, 8'h40);
    tick();
    check("sq_pc_no_inc", pc, 8'h40);
    tick();
    check("sq_next_addr", mem_addr, 8'h40);
    tick();
    check("sq_next_valid", instr_valid, 1'b1);
    check("sq_next_instr", instr, 8'hC4);
    fetch_req = 1'b0;
    tick();
    check("sq_pc_after", pc, 8'h41);

    // Protection boundary (behaviour depends on build)
    data_op(1'b1, 8'h05, 8'h99, ~WPROT, WPROT);
    check("prot_mem_05", mem[8'h05], WPROT ? 8'h55 : 8'h99);
    data_op(1'b1, 8'h10, 8'h88, 1'b1, 1'b0);
    check("prot_mem_10", mem[8'h10], 8'h88);

    // Reset during ACCESS of a store
    d_valid = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
    tick();
    d_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_rw_cut", mem_rw, 1'b0);
    tick();
    check("mr_mem_20", mem[8'h20], 8'h11);
    check("mr_pc", pc, 8'h00);
    check("mr_d_ready", d_ready, 1'b1);
    check("mr_mem_rw", mem_rw, 1'b0);
    check("mr_mem_addr", mem_addr, 8'h00);
    check("mr_mem_wdata", mem_wdata, 8'h00);
    check("mr_instr", instr, 8'h00);
    check("mr_d_rdata", d_rdata, 8'h00);
    check("mr_valids", {instr_valid, d_rsp_valid, wr_fault}, 3'b000);
    rst_n = 1'b1;
    tick();
    check("mr_no_rsp", d_rsp_valid, 1'b0);
    check("mr_mem_20_after", mem[8'h20], 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
